// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited requests
// to an in-order instruction memory, a small instruction buffer, and flushing
// of in-flight and buffered work on taken-branch redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory request
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response (in request order)
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // taken-branch redirect from execute
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // instruction stream to the core
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDIT_LIMIT     = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_unit: FIFO_DEPTH must be a power of two and at least 2");
  end

  // Fetch-side state
  logic [31:0]   fetch_pc;     // address of the next request
  logic [31:0]   rsp_pc;       // PC belonging to the next kept response
  logic [CW-1:0] outstanding;  // accepted requests still owed a response
  logic [CW-1:0] drop;         // owed responses that belong to flushed requests

  // Instruction buffer
  logic [31:0]   buf_data [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Per-cycle events
  logic          req_fire;     // request handshake completes this cycle
  logic          rsp_take;     // response matches an outstanding request
  logic          push;         // response word is written into the buffer
  logic          pop;          // core consumes the head entry
  logic [CW:0]   credit_used;  // buffer slots already promised
  logic [31:0]   redirect_target;

  assign credit_used     = {1'b0, outstanding} + {1'b0, count};
  assign redirect_target = redirect_pc & ~32'h3;
  assign imem_req_addr   = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A stray response with nothing outstanding (e.g. for a request issued
  // before reset) is ignored entirely.
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  // A response is kept only if it is not owed to a flushed request and no
  // redirect is flushing the buffer this cycle.
  assign push     = rsp_take && (drop == '0) && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  // Request credit check and head-of-buffer presentation to the core.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    inst_data      = '0;
    inst_pc        = '0;
    // Issuing only while outstanding + buffered < depth guarantees every
    // returning word has a free slot, so the buffer can never overflow.
    if (!reset && !redirect_valid && (credit_used < CREDIT_LIMIT)) begin
      imem_req_valid = 1'b1;
    end
    if (!reset && (count != '0)) begin
      inst_valid = 1'b1;
      inst_data  = buf_data[rd_ptr];
      inst_pc    = buf_pc[rd_ptr];
    end
  end

  // Fetch PC, response PC and the outstanding/drop bookkeeping.
  // NOTE: state registers use non-blocking assignments so every block sees
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC_ALIGNED;
      rsp_pc      <= RESET_PC_ALIGNED;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      // No request fires during a redirect, so this also covers that cycle.
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        // Everything still owed after this cycle predates the redirect, so
        // all of it is discarded; older drop credit is already included.
        drop     <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (rsp_take && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage for kept response words and their PCs.
  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // by count, and empty slots are never presented to the core.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order instruction memory model returning
// addr+0x100, directed scenarios with hand-computed expected instructions
// queued into a scoreboard, and an independent monitor that checks every
// instruction the core consumes.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  // Second instance with a reset PC near the top of the address space.
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_inst_valid;
  logic        w_inst_ready;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   mem_lat   = 1;
  bit   mem_ready = 1'b1;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .inst_valid     (w_inst_valid),
    .inst_ready     (w_inst_ready),
    .inst_data      (w_inst_data),
    .inst_pc        (w_inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Memory model: accepts when ready, answers in order mem_lat cycles later.
  initial begin
    mem_t m;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_req_ready = mem_ready;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_q[0].addr + 32'h100;
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr;
        m.due  = cyc + mem_lat;
        mem_q.push_back(m);
      end
    end
  end

  // Monitor: every consumed instruction must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !redirect_valid && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      mem_ready      = 1'b1;
    end
    #3;
    check("rst req_valid", imem_req_valid, 0);
    check("rst inst_valid", inst_valid, 0);
    check("rst req_addr", imem_req_addr, 32'h0);
    check("rst inst_data", inst_data, 32'h0);
    check("rst inst_pc", inst_pc, 32'h0);
    check("rst wrap req_addr", w_req_addr, 32'hFFFF_FFF8);
  endtask

  initial begin
    reset            = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    inst_ready       = 1'b0;
    w_req_ready      = 1'b1;
    w_rsp_valid      = 1'b0;
    w_rsp_data       = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_inst_ready     = 1'b0;

    // Cold start with a zero-wait memory; also steps the wrap instance.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 8; i++) exp_push(32'(i * 4), 32'(i * 4) + 32'h100);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reset      = 1'b0;
      inst_ready = (c <= 9);
      #3;
      case (c)
        0: begin
          check("cold c0 req_valid", imem_req_valid, 1);
          check("cold c0 req_addr", imem_req_addr, 32'h0);
          check("cold c0 inst_valid", inst_valid, 0);
          check("wrap c0 req_valid", w_req_valid, 1);
          check("wrap c0 req_addr", w_req_addr, 32'hFFFF_FFF8);
        end
        1: begin
          check("cold c1 inst_valid", inst_valid, 0);
          check("cold c1 req_addr", imem_req_addr, 32'h4);
          check("wrap c1 req_addr", w_req_addr, 32'hFFFF_FFFC);
        end
        2: check("wrap c2 req_addr", w_req_addr, 32'h0);
        3: check("wrap c3 req_addr", w_req_addr, 32'h4);
        4: begin
          check("wrap c4 req_valid", w_req_valid, 0);
          check("wrap c4 inst_valid", w_inst_valid, 0);
          check("wrap c4 inst_data", w_inst_data, 32'h0);
          check("wrap c4 inst_pc", w_inst_pc, 32'h0);
        end
        default: ;
      endcase
      if (c >= 2 && c <= 9) check($sformatf("cold c%0d inst_valid", c), inst_valid, 1);
    end
    check("cold leftover", exp_q.size(), 0);

    // Backpressure: buffer fills to four entries, then drains in order.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) exp_push(32'(i * 4), 32'(i * 4) + 32'h100);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      reset      = 1'b0;
      inst_ready = (c >= 10 && c <= 15);
      #3;
      if (c <= 3) check($sformatf("bp c%0d req_valid", c), imem_req_valid, 1);
      if (c >= 4 && c <= 10) check($sformatf("bp c%0d req_valid", c), imem_req_valid, 0);
      if (c == 9) begin
        check("bp c9 inst_valid", inst_valid, 1);
        check("bp c9 inst_pc", inst_pc, 32'h0);
        check("bp c9 inst_data", inst_data, 32'h100);
        check("bp c9 req_addr", imem_req_addr, 32'h10);
      end
      if (c == 11) begin
        check("bp c11 req_valid", imem_req_valid, 1);
        check("bp c11 req_addr", imem_req_addr, 32'h10);
      end
    end
    check("bp leftover", exp_q.size(), 0);

    // Redirect to an unaligned target with two requests in flight.
    do_reset();
    mem_lat = 3;
    exp_push(32'h200, 32'h300);
    exp_push(32'h204, 32'h304);
    exp_push(32'h208, 32'h308);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = (c == 2);
      redirect_pc    = 32'h203;
      inst_ready     = (c <= 9);
      #3;
      if (c == 2) check("rd2 c2 req_valid", imem_req_valid, 0);
      if (c == 3) begin
        check("rd2 c3 req_valid", imem_req_valid, 1);
        check("rd2 c3 req_addr", imem_req_addr, 32'h200);
      end
      if (c == 4) check("rd2 c4 req_addr", imem_req_addr, 32'h204);
      if (c == 5 || c == 6) check($sformatf("rd2 c%0d inst_valid", c), inst_valid, 0);
      if (c == 7) check("rd2 c7 inst_valid", inst_valid, 1);
    end
    check("rd2 leftover", exp_q.size(), 0);

    // Redirect coinciding with a response, a ready memory and a ready core.
    do_reset();
    mem_lat = 1;
    exp_push(32'h0, 32'h100);
    exp_push(32'h4, 32'h104);
    exp_push(32'h400, 32'h500);
    exp_push(32'h404, 32'h504);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = (c == 4);
      redirect_pc    = 32'h400;
      inst_ready     = (c <= 8);
      #3;
      if (c == 4) begin
        check("sim c4 req_valid", imem_req_valid, 0);
        check("sim c4 inst_valid", inst_valid, 1);
      end
      if (c == 5) begin
        check("sim c5 inst_valid", inst_valid, 0);
        check("sim c5 req_valid", imem_req_valid, 1);
        check("sim c5 req_addr", imem_req_addr, 32'h400);
      end
      if (c == 6) check("sim c6 inst_valid", inst_valid, 0);
      if (c == 7) check("sim c7 inst_valid", inst_valid, 1);
    end
    check("sim leftover", exp_q.size(), 0);

    // Back-to-back redirects: the second wins, drop count carries over.
    do_reset();
    mem_lat = 3;
    exp_push(32'h500, 32'h600);
    exp_push(32'h504, 32'h604);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = (c == 2 || c == 3);
      redirect_pc    = (c == 2) ? 32'h300 : 32'h500;
      inst_ready     = (c <= 9);
      #3;
      if (c == 2 || c == 3) check($sformatf("b2b c%0d req_valid", c), imem_req_valid, 0);
      if (c == 4) begin
        check("b2b c4 req_valid", imem_req_valid, 1);
        check("b2b c4 req_addr", imem_req_addr, 32'h500);
      end
      if (c >= 5 && c <= 7) check($sformatf("b2b c%0d inst_valid", c), inst_valid, 0);
      if (c == 8) check("b2b c8 inst_valid", inst_valid, 1);
    end
    check("b2b leftover", exp_q.size(), 0);

    // Address wrap through the top of the address space.
    do_reset();
    mem_lat = 1;
    exp_push(32'hFFFF_FFF8, 32'h0000_00F8);
    exp_push(32'hFFFF_FFFC, 32'h0000_00FC);
    exp_push(32'h0000_0000, 32'h0000_0100);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = (c == 0);
      redirect_pc    = 32'hFFFF_FFF8;
      inst_ready     = (c <= 5);
      #3;
      if (c == 0) check("wrap c0 req_valid", imem_req_valid, 0);
      if (c == 1) check("wrap c1 req_addr", imem_req_addr, 32'hFFFF_FFF8);
      if (c == 2) check("wrap c2 req_addr", imem_req_addr, 32'hFFFF_FFFC);
      if (c == 3) begin
        check("wrap c3 req_valid", imem_req_valid, 1);
        check("wrap c3 req_addr", imem_req_addr, 32'h0);
      end
    end
    check("wrap leftover", exp_q.size(), 0);

    // Reset with two requests outstanding; their late responses are ignored.
    do_reset();
    mem_lat = 3;
    exp_push(32'h0, 32'h100);
    exp_push(32'h4, 32'h104);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      reset      = (c == 2);
      mem_ready  = !(c == 3 || c == 4);
      inst_ready = (c >= 5 && c <= 10);
      #3;
      if (c == 2) begin
        check("mid c2 req_valid", imem_req_valid, 0);
        check("mid c2 inst_valid", inst_valid, 0);
      end
      if (c == 3) begin
        check("mid c3 req_valid", imem_req_valid, 1);
        check("mid c3 req_addr", imem_req_addr, 32'h0);
      end
      if (c >= 3 && c <= 8) check($sformatf("mid c%0d inst_valid", c), inst_valid, 0);
      if (c == 9) check("mid c9 inst_valid", inst_valid, 1);
    end
    check("mid leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
